// File: rtl/multiplex_pkg.sv
// multiplex_pkg
//   Shared helpers for the N-to-1 stream multiplexer slice.
//   token_in_range: true when a select token names an existing slave port.
//   Tokens outside 0..N-1 can only occur when N is not a power of two; the
//   select stage acknowledges and drops them.
package multiplex_pkg;

  function automatic logic token_in_range(input int unsigned tok, input int unsigned n);
    return tok < n;
  endfunction

endpackage

// File: rtl/multiplex_if.sv
// multiplex_if
//   Bundles the three stream channels of the multiplexer.
//   Every channel transfers in a cycle where stb && ack at posedge clk; the
//   producer holds stb high and dat stable until that transfer, and ack may
//   depend combinationally on stb.
//   Signals:
//     s_dat/s_stb/s_ack : N slave data streams, port i in s_dat[i*W +: W]
//     n_dat/n_stb/n_ack : select token stream, SW bits per token
//     m_dat/m_stb/m_ack : single master output stream
//   Modports:
//     slave  : the multiplexer's view
//     master : the environment's view (producers, token source, consumer)
interface multiplex_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N*W-1:0] s_dat;
  logic [N-1:0]   s_stb;
  logic [N-1:0]   s_ack;
  logic [SW-1:0]  n_dat;
  logic           n_stb;
  logic           n_ack;
  logic [W-1:0]   m_dat;
  logic           m_stb;
  logic           m_ack;

  modport slave (
    input  s_dat, s_stb, n_dat, n_stb, m_ack,
    output s_ack, n_ack, m_dat, m_stb
  );

  modport master (
    output s_dat, s_stb, n_dat, n_stb, m_ack,
    input  s_ack, n_ack, m_dat, m_stb
  );
endinterface

// File: rtl/multiplex_select.sv
// multiplex_select
//   Holds one select token (sel_q/sel_vld) and runs the token handshake.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     n_dat    : incoming token
//     n_stb    : token strobe
//     n_ack    : token acknowledge (free slot, or slot emptying this cycle)
//     consume  : the held token is used by a data transfer this cycle
//     sel      : held token value
//     vld      : a token is held
module multiplex_select
  import multiplex_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] n_dat,
  input  logic          n_stb,
  output logic          n_ack,
  input  logic          consume,
  output logic [SW-1:0] sel,
  output logic          vld
);

  logic [SW-1:0] sel_q;
  logic          sel_vld;
  logic          take;

  // A token is accepted when the slot is empty or is being emptied now,
  // which lets tokens stream at one per cycle.
  assign n_ack = !rst && (!sel_vld || consume);
  assign take  = n_stb && n_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= '0;
      sel_vld <= 1'b0;
    end else if (take) begin
      if (token_in_range(32'(n_dat), N)) begin
        sel_q   <= n_dat;
        sel_vld <= 1'b1;
      end else begin
        // Out-of-range token: acknowledged but never steers a transfer.
        sel_vld <= 1'b0;
      end
    end else if (consume) begin
      sel_vld <= 1'b0;
    end
  end

  assign sel = sel_q;
  assign vld = sel_vld;

endmodule

// File: rtl/multiplex.sv
// multiplex
//   N-to-1 stream multiplexer steered by a select token stream. Each
//   transaction takes one token, then one word from the selected slave port,
//   and forwards that word on the master port one cycle after acceptance.
//   Ports:
//     clk : clock
//     rst : asynchronous active-high reset
//     bus : multiplex_if.slave carrying slave, select and master channels
module multiplex
  import multiplex_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4
) (
  input logic       clk,
  input logic       rst,
  multiplex_if.slave bus
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [SW-1:0] sel_q;
  logic          sel_vld;
  logic          s_fire;
  logic          out_free;
  logic [N-1:0]  s_ack_w;
  logic [W-1:0]  sel_word;
  logic [W-1:0]  out_q;
  logic          out_vld;

  multiplex_select #(
    .N (N),
    .SW(SW)
  ) u_select (
    .clk    (clk),
    .rst    (rst),
    .n_dat  (bus.n_dat),
    .n_stb  (bus.n_stb),
    .n_ack  (bus.n_ack),
    .consume(s_fire),
    .sel    (sel_q),
    .vld    (sel_vld)
  );

  // The output register can take a word when empty or when its current word
  // leaves this cycle.
  assign out_free = !out_vld || bus.m_ack;

  // Only the selected port is ever acknowledged; the others stall.
  always_comb begin
    s_ack_w  = '0;
    sel_word = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_q == SW'(i)) begin
        s_ack_w[i] = !rst && sel_vld && out_free;
        sel_word   = bus.s_dat[i*W +: W];
      end
    end
  end

  assign s_fire    = |(s_ack_w & bus.s_stb);
  assign bus.s_ack = s_ack_w;

  // A new word overwriting a departing one keeps out_vld high so the stream
  // runs at one word per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      out_vld <= 1'b0;
    end else if (s_fire) begin
      out_q   <= sel_word;
      out_vld <= 1'b1;
    end else if (out_vld && bus.m_ack) begin
      out_vld <= 1'b0;
    end
  end

  assign bus.m_dat = out_q;
  assign bus.m_stb = out_vld;

endmodule

// File: tb/tb_multiplex.sv
// tb_multiplex
//   Self-checking bench for multiplex with W=8, N=4. Inputs change 1ns after
//   the rising edge; outputs and handshakes are sampled on the falling edge.
module tb_multiplex;

  localparam int W = 8;
  localparam int N = 4;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  multiplex_if #(.W(W), .N(N)) bus ();

  multiplex #(.W(W), .N(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.n_stb = 1'b0;
    bus.n_dat = '0;
    bus.s_stb = '0;
    bus.s_dat = '0;
    bus.m_ack = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.n_stb = 1'b1;
    bus.s_stb = '1;
    bus.m_ack = 1'b1;
    #1;
    n_cmp++; if (bus.m_stb !== 1'b0) begin n_err++; $display("FAIL reset_m_stb got %b want 0", bus.m_stb); end
    n_cmp++; if (bus.n_ack !== 1'b0) begin n_err++; $display("FAIL reset_n_ack got %b want 0", bus.n_ack); end
    n_cmp++; if (bus.s_ack !== 4'b0000) begin n_err++; $display("FAIL reset_s_ack got %b want 0000", bus.s_ack); end
    n_cmp++; if (bus.m_dat !== 8'h00) begin n_err++; $display("FAIL reset_m_dat got %h want 00", bus.m_dat); end
    idle_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (bus.n_ack !== 1'b1) begin n_err++; $display("FAIL post_reset_n_ack got %b want 1", bus.n_ack); end
  endtask

  task automatic test_single();
    logic [N-1:0] ack_seen;
    apply_reset();
    bus.s_dat = {8'h33, 8'hA5, 8'h11, 8'h0F};
    bus.s_stb = 4'hF;
    bus.n_dat = 2'd2;
    bus.n_stb = 1'b1;
    #1;
    n_cmp++; if (bus.n_ack !== 1'b1) begin n_err++; $display("FAIL single_n_ack got %b want 1", bus.n_ack); end
    step();                       // token 2 transferred
    bus.n_stb = 1'b0;
    #1;
    n_cmp++; if (bus.s_ack !== 4'b0100) begin n_err++; $display("FAIL single_s_ack got %b want 0100", bus.s_ack); end
    n_cmp++; if (bus.m_stb !== 1'b0) begin n_err++; $display("FAIL single_m_stb_early got %b want 0", bus.m_stb); end
    step();                       // port 2 word accepted
    n_cmp++; if (bus.m_stb !== 1'b1) begin n_err++; $display("FAIL single_m_stb got %b want 1", bus.m_stb); end
    n_cmp++; if (bus.m_dat !== 8'hA5) begin n_err++; $display("FAIL single_m_dat got %h want a5", bus.m_dat); end
    bus.s_stb = 4'b1011;
    bus.m_ack = 1'b1;
    ack_seen = '0;
    repeat (6) begin
      @(negedge clk);
      ack_seen = ack_seen | bus.s_ack;
      step();
    end
    n_cmp++; if (ack_seen !== 4'b0000) begin n_err++; $display("FAIL single_stalled_ports got %b want 0000", ack_seen); end
    n_cmp++; if (bus.m_stb !== 1'b0) begin n_err++; $display("FAIL single_drained got %b want 0", bus.m_stb); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [4];
    logic [7:0] got_q[$];
    int         cyc_q[$];
    int         tok;
    int         cycle;
    logic       nf;
    want[0] = 8'h10; want[1] = 8'h21; want[2] = 8'h32; want[3] = 8'h43;
    apply_reset();
    bus.s_dat = {8'h43, 8'h32, 8'h21, 8'h10};
    bus.s_stb = 4'hF;
    bus.m_ack = 1'b1;
    bus.n_stb = 1'b1;
    bus.n_dat = 2'd0;
    tok = 0;
    cycle = 0;
    while (cycle < 20 && got_q.size() < 4) begin
      @(negedge clk);
      nf = bus.n_stb && bus.n_ack;
      if (bus.m_stb && bus.m_ack) begin
        got_q.push_back(bus.m_dat);
        cyc_q.push_back(cycle);
      end
      step();
      cycle++;
      if (nf) begin
        if (tok == 3) bus.n_stb = 1'b0;
        else begin
          tok++;
          bus.n_dat = 2'(tok);
        end
      end
    end
    n_cmp++; if (got_q.size() !== 4) begin n_err++; $display("FAIL b2b_count got %0d want 4", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 4; k++) begin
      n_cmp++; if (got_q[k] !== want[k]) begin n_err++; $display("FAIL b2b_word%0d got %h want %h", k, got_q[k], want[k]); end
      n_cmp++; if (cyc_q[k] !== 2 + k) begin n_err++; $display("FAIL b2b_cycle%0d got %0d want %0d", k, cyc_q[k], 2 + k); end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [7:0] want [3];
    logic [7:0] got_q[$];
    logic       nf;
    logic [N-1:0] sf;
    want[0] = 8'h7E; want[1] = 8'h81; want[2] = 8'h92;
    apply_reset();
    bus.n_stb = 1'b1;
    bus.n_dat = 2'd1;
    bus.s_dat[15:8] = 8'h7E;
    bus.s_stb = 4'b0010;
    bus.m_ack = 1'b0;
    step();                       // first token (1) transferred
    n_cmp++; if (bus.n_ack !== 1'b1) begin n_err++; $display("FAIL bp_second_token_ack got %b want 1", bus.n_ack); end
    step();                       // 7E accepted, second token (1) held
    bus.s_dat[15:8] = 8'h81;
    bus.s_dat[23:16] = 8'h92;
    bus.n_dat = 2'd2;
    bus.s_stb = 4'b0110;
    #1;
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (bus.m_stb !== 1'b1 || bus.m_dat !== 8'h7E) begin n_err++; $display("FAIL bp_hold%0d got stb=%b dat=%h want stb=1 dat=7e", c, bus.m_stb, bus.m_dat); end
      n_cmp++; if (bus.s_ack !== 4'b0000 || bus.n_ack !== 1'b0) begin n_err++; $display("FAIL bp_stall%0d got s_ack=%b n_ack=%b want 0000/0", c, bus.s_ack, bus.n_ack); end
      step();
    end
    bus.m_ack = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      nf = bus.n_stb && bus.n_ack;
      sf = bus.s_stb & bus.s_ack;
      if (bus.m_stb && bus.m_ack) got_q.push_back(bus.m_dat);
      step();
      if (nf) bus.n_stb = 1'b0;
      bus.s_stb = bus.s_stb & ~sf;
    end
    n_cmp++; if (got_q.size() !== 3) begin n_err++; $display("FAIL bp_drain_count got %0d want 3", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 3; k++) begin
      n_cmp++; if (got_q[k] !== want[k]) begin n_err++; $display("FAIL bp_drain%0d got %h want %h", k, got_q[k], want[k]); end
    end
    idle_inputs();
  endtask

  task automatic test_delayed_strobe();
    apply_reset();
    bus.n_stb = 1'b1;
    bus.n_dat = 2'd3;
    bus.s_dat[31:24] = 8'h3C;
    bus.m_ack = 1'b1;
    step();                       // token 3 transferred
    bus.n_stb = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (bus.n_ack !== 1'b0 || bus.m_stb !== 1'b0) begin n_err++; $display("FAIL delay_wait%0d got n_ack=%b m_stb=%b want 0/0", c, bus.n_ack, bus.m_stb); end
      step();
    end
    bus.s_stb = 4'b1000;
    #1;
    n_cmp++; if (bus.s_ack !== 4'b1000) begin n_err++; $display("FAIL delay_s_ack got %b want 1000", bus.s_ack); end
    step();
    bus.s_stb = '0;
    n_cmp++; if (bus.m_stb !== 1'b1 || bus.m_dat !== 8'h3C) begin n_err++; $display("FAIL delay_word got stb=%b dat=%h want stb=1 dat=3c", bus.m_stb, bus.m_dat); end
    step();
    n_cmp++; if (bus.m_stb !== 1'b0) begin n_err++; $display("FAIL delay_drain got %b want 0", bus.m_stb); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [7:0] got_q[$];
    logic       nf;
    logic [N-1:0] sf;
    apply_reset();
    bus.n_stb = 1'b1;
    bus.n_dat = 2'd1;
    bus.s_dat[15:8] = 8'h5A;
    bus.s_stb = 4'b0010;
    step();                       // token transferred
    step();                       // word accepted, second token held
    n_cmp++; if (bus.m_stb !== 1'b1 || bus.n_ack !== 1'b0) begin n_err++; $display("FAIL rmid_setup got m_stb=%b n_ack=%b want 1/0", bus.m_stb, bus.n_ack); end
    bus.m_ack = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.m_stb !== 1'b0) begin n_err++; $display("FAIL rmid_m_stb got %b want 0", bus.m_stb); end
    n_cmp++; if (bus.n_ack !== 1'b0 || bus.s_ack !== 4'b0000) begin n_err++; $display("FAIL rmid_acks got n_ack=%b s_ack=%b want 0/0000", bus.n_ack, bus.s_ack); end
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.n_stb = 1'b1;
    bus.n_dat = 2'd0;
    bus.s_dat[7:0] = 8'hC3;
    bus.s_stb = 4'b0001;
    bus.m_ack = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      nf = bus.n_stb && bus.n_ack;
      sf = bus.s_stb & bus.s_ack;
      if (bus.m_stb && bus.m_ack) got_q.push_back(bus.m_dat);
      step();
      if (nf) bus.n_stb = 1'b0;
      bus.s_stb = bus.s_stb & ~sf;
    end
    n_cmp++; if (got_q.size() !== 1) begin n_err++; $display("FAIL rmid_count got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q[0] !== 8'hC3) begin n_err++; $display("FAIL rmid_word got %h want c3", got_q[0]); end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [W-1:0] port_q [N][$];
    logic [1:0]   tok_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] w;
    logic [1:0]   t;
    logic         nf;
    logic [N-1:0] sf;
    int           cycles;
    int           words;
    apply_reset();
    // Reference: each token takes the next unsent word of its port, and the
    // output stream is those words in token order.
    for (int i = 0; i < 1000; i++) begin
      t = 2'($urandom_range(0, N - 1));
      w = 8'($urandom_range(0, 255));
      tok_q.push_back(t);
      port_q[t].push_back(w);
      exp_q.push_back(w);
    end
    cycles = 0;
    words = 0;
    while (exp_q.size() > 0 && cycles < 30000) begin
      if (!bus.n_stb && tok_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        bus.n_stb = 1'b1;
        bus.n_dat = tok_q.pop_front();
      end
      for (int i = 0; i < N; i++) begin
        if (!bus.s_stb[i] && port_q[i].size() > 0 && $urandom_range(0, 3) != 0) begin
          bus.s_stb[i] = 1'b1;
          bus.s_dat[i*W +: W] = port_q[i].pop_front();
        end
      end
      bus.m_ack = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      nf = bus.n_stb && bus.n_ack;
      sf = bus.s_stb & bus.s_ack;
      if (bus.m_stb && bus.m_ack) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_extra got %h want no word", bus.m_dat);
        end else begin
          w = exp_q.pop_front();
          if (bus.m_dat !== w) begin n_err++; $display("FAIL rand_word%0d got %h want %h", words, bus.m_dat, w); end
        end
        words++;
      end
      step();
      if (nf) bus.n_stb = 1'b0;
      bus.s_stb = bus.s_stb & ~sf;
      cycles++;
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL rand_timeout got %0d words left want 0", exp_q.size()); end
    n_cmp++; if (words !== 1000) begin n_err++; $display("FAIL rand_count got %0d want 1000", words); end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_delayed_strobe();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
